cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit that sequences the small accumulator CPU datapath (ALU, accumulator, zero/carry flag registers). It fetches instructions over a req/valid memory handshake, decodes them, and drives ALU op, immediate and write-enables. It also resolves jumps and halts. The datapath stays external; this block owns the PC, the instruction register and the state machine.

Parameters:
WIDTH, 4, datapath/immediate width in bits
ADDR_W, 4, PC / instruction address width (program of 2^ADDR_W words)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request, high throughout FETCH
imem_addr  output  ADDR_W  fetch address (equals pc)
imem_valid  input  1  instruction word valid; sampled only in FETCH
imem_data  input  4+WIDTH  instruction: [WIDTH+3:WIDTH] opcode, [WIDTH-1:0] imm
zero_in  input  1  datapath zero flag register
carry_in  input  1  datapath carry flag register
alu_op  output  3  0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
alu_imm  output  WIDTH  ALU B operand (immediate)
acc_we  output  1  accumulator write strobe
flags_we  output  1  zero/carry write strobe
pc  output  ADDR_W  program counter
state  output  3  0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK, 4 HALT
halted  output  1  high in HALT

Behaviour:
- Reset (rst=1 at a clk edge, overrides everything including mid-fetch or mid-writeback): state=FETCH, pc=0, ir=0, alu_op=0, alu_imm=0, acc_we=0, flags_we=0, halted=0. imem_req=0 while rst is high.
- Outputs are Moore: all outputs are decoded from registered state or registers, never from inputs.
- Opcodes:
  - 0 NOP
  - 1 LDI (PASS_B)
  - 2 ADD
  - 3 SUB
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 JMP
  - 8 JZ
  - 9 JC
  - F HLT
  - A–E are treated as NOP.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_valid=0: remain in FETCH, pc held (unbounded wait).
  - imem_valid=1: ir<=imem_data, pc<=pc+1 modulo 2^ADDR_W, go to DECODE.
- DECODE: alu_op and alu_imm are registered from ir. They are valid from EXECUTE and held until the next DECODE. For non-ALU opcodes they stay at 0/imm. Next state is EXECUTE.
- EXECUTE: zero_in and carry_in are sampled this cycle.
  - JMP: pc<=imm[ADDR_W-1:0].
  - JZ: jump if zero_in=1, else pc unchanged.
  - JC: jump if carry_in=1, else pc unchanged.
  - Next state: ALU opcodes (1–6) go to WRITEBACK; HLT goes to HALT; all others go to FETCH.
- WRITEBACK: acc_we=1 and flags_we=1 for exactly this one cycle, then FETCH.
- HALT: halted=1, imem_req=0, all strobes 0. Held until rst.
- Latency, with imem_valid high on the first FETCH cycle:
  - ALU instruction takes 4 cycles.
  - NOP/jump instruction takes 3 cycles.
  - Each FETCH wait cycle adds 1.
- Flags written in WRITEBACK are visible to the next instruction's EXECUTE. No forwarding is needed.
- The jump target uses the low ADDR_W bits of imm; the upper bits are ignored when WIDTH>ADDR_W.
- imem_valid outside FETCH is ignored. A late valid never corrupts ir.

Test Plan:
1. Reset: rst=1 for 2 cycles -> pc=0, state=0, imem_req=0, acc_we=0, halted=0. First cycle after release: imem_req=1, imem_addr=0.
2. Program LDI 5 (0x15) then ADD 3 (0x23), imem_valid always 1:
   - alu_op=0, alu_imm=5, acc_we/flags_we pulse on cycle 4.
   - alu_op=1, alu_imm=3, pulse on cycle 8.
   - pc=2 after cycle 8.
3. Fetch stall: imem_valid held 0 for 3 cycles -> state stays FETCH, imem_req=1, pc=0 unchanged. DECODE entered on the cycle after valid=1. The acc_we pulse lands 3 cycles later than in scenario 2.
4. Jumps:
   - JZ 9 (0x89) with zero_in=1 -> pc=9. With zero_in=0 -> pc=1.
   - JC 6 with carry_in=1 -> pc=6.
   - NOP at address 15 -> pc wraps to 0.
5. HLT (0xF0) -> EXECUTE then HALT. halted=1, imem_req=0, no strobes for 10 cycles. rst returns pc=0, halted=0.
6. rst asserted during WRITEBACK of ADD -> the next cycle has acc_we=0, state=FETCH, pc=0. A stray imem_valid=1 during DECODE leaves ir unchanged.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the small accumulator CPU.
// Owns the PC, instruction register and the FETCH/DECODE/EXECUTE/WRITEBACK/HALT
// sequencer; the ALU, accumulator and flag registers live in the external datapath.
module cpu_ctrl_fsm #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [WIDTH+3:0]   imem_data,
    input  logic               zero_in,
    input  logic               carry_in,
    output logic [2:0]         alu_op,
    output logic [WIDTH-1:0]   alu_imm,
    output logic               acc_we,
    output logic               flags_we,
    output logic [ADDR_W-1:0]  pc,
    output logic [2:0]         state,
    output logic               halted
);

    localparam logic [2:0] StFetch     = 3'd0;
    localparam logic [2:0] StDecode    = 3'd1;
    localparam logic [2:0] StExecute   = 3'd2;
    localparam logic [2:0] StWriteback = 3'd3;
    localparam logic [2:0] StHalt      = 3'd4;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLdi = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpAnd = 4'h4;
    localparam logic [3:0] OpOr  = 4'h5;
    localparam logic [3:0] OpXor = 4'h6;
    localparam logic [3:0] OpJmp = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpJc  = 4'h9;
    localparam logic [3:0] OpHlt = 4'hF;

    localparam logic [ADDR_W-1:0] PcOne = ADDR_W'(1);

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [WIDTH+3:0]    ir_q, ir_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic [WIDTH-1:0]    alu_imm_q, alu_imm_d;

    logic [3:0]          opcode;
    logic [WIDTH-1:0]    imm;
    logic [ADDR_W-1:0]   jmp_tgt;
    logic                is_alu;

    assign opcode = ir_q[WIDTH+3:WIDTH];
    assign imm    = ir_q[WIDTH-1:0];

    // Jump target takes the low ADDR_W bits of imm (zero-extended if imm is narrower).
    if (ADDR_W <= WIDTH) begin : g_tgt_trunc
        assign jmp_tgt = imm[ADDR_W-1:0];
    end else begin : g_tgt_ext
        assign jmp_tgt = {{(ADDR_W - WIDTH){1'b0}}, imm};
    end

    // Opcodes LDI..XOR are the ones that drive the accumulator.
    always_comb begin
        is_alu = 1'b0;
        case (opcode)
            OpLdi, OpAdd, OpSub, OpAnd, OpOr, OpXor: is_alu = 1'b1;
            default:                                 is_alu = 1'b0;
        endcase
    end

    // Next-state, PC, IR and ALU control computation.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_op_d  = alu_op_q;
        alu_imm_d = alu_imm_q;
        case (state_q)
            StFetch: begin
                // imem_valid is only honoured here, so a late valid never touches ir.
                if (imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PcOne;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // ALU opcodes 1..6 map onto ALU ops 0..5; everything else shows PASS_B.
                alu_op_d  = is_alu ? 3'(opcode - 4'd1) : 3'd0;
                alu_imm_d = imm;
                state_d   = StExecute;
            end
            StExecute: begin
                case (opcode)
                    OpJmp:   pc_d = jmp_tgt;
                    OpJz:    if (zero_in)  pc_d = jmp_tgt;
                    OpJc:    if (carry_in) pc_d = jmp_tgt;
                    default: pc_d = pc_q;
                endcase
                if (is_alu) begin
                    state_d = StWriteback;
                end else if (opcode == OpHlt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            StWriteback: state_d = StFetch;
            StHalt:      state_d = StHalt;
            default:     state_d = StFetch;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            ir_q      <= '0;
            alu_op_q  <= 3'd0;
            alu_imm_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_op_q  <= alu_op_d;
            alu_imm_q <= alu_imm_d;
        end
    end

    // Moore outputs; imem_req is additionally held low while reset is asserted.
    assign imem_req  = (state_q == StFetch) && !rst;
    assign imem_addr = pc_q;
    assign alu_op    = alu_op_q;
    assign alu_imm   = alu_imm_q;
    assign acc_we    = (state_q == StWriteback);
    assign flags_we  = (state_q == StWriteback);
    assign pc        = pc_q;
    assign state     = state_q;
    assign halted    = (state_q == StHalt);

    // NOP is the default path through EXECUTE; kept named for readability.
    logic unused_nop;
    assign unused_nop = (opcode == OpNop);

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed programs plus an
// instruction-level reference model compared on every cycle.
module tb_cpu_ctrl_fsm;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned ADDR_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_valid = 1'b1;
    logic [WIDTH+3:0]   imem_data;
    logic               zero_in = 1'b0;
    logic               carry_in = 1'b0;
    logic [2:0]         alu_op;
    logic [WIDTH-1:0]   alu_imm;
    logic               acc_we;
    logic               flags_we;
    logic [ADDR_W-1:0]  pc;
    logic [2:0]         state;
    logic               halted;

    logic [7:0] mem [16];
    logic       ovr_en = 1'b0;
    logic [7:0] ovr_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    assign imem_data = ovr_en ? ovr_data : mem[imem_addr];

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .zero_in    (zero_in),
        .carry_in   (carry_in),
        .alu_op     (alu_op),
        .alu_imm    (alu_imm),
        .acc_we     (acc_we),
        .flags_we   (flags_we),
        .pc         (pc),
        .state      (state),
        .halted     (halted)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    // m_phase: 0 waiting for fetch, 1 instruction held, 2 executing, 3 writing back,
    // 4 halted. Expected outputs follow directly from the instruction rules.
    bit         m_known = 0;
    int         m_phase = 0;
    logic [3:0] m_pc = 0;
    logic [7:0] m_ir = 0;
    int         m_alu_op = 0;
    int         m_alu_imm = 0;

    always @(posedge clk) begin
        int op;
        op = int'(m_ir[7:4]);
        if (rst) begin
            m_known = 1;
            m_phase = 0;
            m_pc = 0;
            m_ir = 0;
            m_alu_op = 0;
            m_alu_imm = 0;
        end else if (m_known) begin
            if (m_phase == 0) begin
                if (imem_valid) begin
                    m_ir = mem[m_pc];
                    m_pc = m_pc + 4'd1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_alu_op  = (op >= 1 && op <= 6) ? op - 1 : 0;
                m_alu_imm = int'(m_ir[3:0]);
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (op == 7 || (op == 8 && zero_in) || (op == 9 && carry_in))
                    m_pc = m_ir[3:0];
                if (op >= 1 && op <= 6) m_phase = 3;
                else if (op == 15)      m_phase = 4;
                else                    m_phase = 0;
            end else if (m_phase == 3) begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("m_state",    int'(state),     m_phase);
            chk("m_pc",       int'(pc),        int'(m_pc));
            chk("m_imem_addr", int'(imem_addr), int'(m_pc));
            chk("m_imem_req", int'(imem_req),  (m_phase == 0 && !rst) ? 1 : 0);
            chk("m_acc_we",   int'(acc_we),    (m_phase == 3) ? 1 : 0);
            chk("m_flags_we", int'(flags_we),  (m_phase == 3) ? 1 : 0);
            chk("m_halted",   int'(halted),    (m_phase == 4) ? 1 : 0);
            chk("m_alu_op",   int'(alu_op),    m_alu_op);
            chk("m_alu_imm",  int'(alu_imm),   m_alu_imm);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    initial begin
        clear_mem();
        mem[0] = 8'h15;  // LDI 5
        mem[1] = 8'h23;  // ADD 3

        // 1. Reset
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_req", int'(imem_req), 0);
        chk("rst_acc_we", int'(acc_we), 0);
        chk("rst_halted", int'(halted), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_req", int'(imem_req), 1);
        chk("rel_addr", int'(imem_addr), 0);

        // 2. LDI 5 ; ADD 3 with valid always high
        repeat (3) step();
        @(negedge clk);
        chk("ldi_acc_we_c4", int'(acc_we), 1);
        chk("ldi_flags_we_c4", int'(flags_we), 1);
        chk("ldi_alu_op", int'(alu_op), 0);
        chk("ldi_alu_imm", int'(alu_imm), 5);
        repeat (4) step();
        @(negedge clk);
        chk("add_acc_we_c8", int'(acc_we), 1);
        chk("add_alu_op", int'(alu_op), 1);
        chk("add_alu_imm", int'(alu_imm), 3);
        chk("add_pc_c8", int'(pc), 2);

        // 3. Fetch stall of 3 cycles
        imem_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_state", int'(state), 0);
            chk("stall_req", int'(imem_req), 1);
            chk("stall_pc", int'(pc), 0);
            step();
        end
        imem_valid = 1'b1;
        step();
        @(negedge clk);
        chk("stall_decode", int'(state), 1);
        repeat (2) step();
        @(negedge clk);
        chk("stall_acc_we_c7", int'(acc_we), 1);
        chk("stall_alu_imm", int'(alu_imm), 5);

        // 4. Jumps
        clear_mem();
        mem[0] = 8'h89;  // JZ 9
        zero_in = 1'b1;
        do_reset();
        repeat (3) step();
        @(negedge clk);
        chk("jz_taken_pc", int'(pc), 9);
        chk("jz_taken_state", int'(state), 0);

        zero_in = 1'b0;
        do_reset();
        repeat (3) step();
        @(negedge clk);
        chk("jz_not_taken_pc", int'(pc), 1);

        mem[0] = 8'h96;  // JC 6
        carry_in = 1'b1;
        do_reset();
        repeat (3) step();
        @(negedge clk);
        chk("jc_taken_pc", int'(pc), 6);

        carry_in = 1'b0;
        mem[0] = 8'h7F;  // JMP 15, NOP at 15
        do_reset();
        repeat (3) step();
        @(negedge clk);
        chk("jmp_pc", int'(pc), 15);
        step();
        @(negedge clk);
        chk("wrap_pc", int'(pc), 0);

        // 5. HLT
        mem[0] = 8'hF0;
        do_reset();
        repeat (2) step();
        @(negedge clk);
        chk("hlt_exec_state", int'(state), 2);
        step();
        @(negedge clk);
        chk("hlt_state", int'(state), 4);
        chk("hlt_halted", int'(halted), 1);
        chk("hlt_req", int'(imem_req), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk("hold_halted", int'(halted), 1);
            chk("hold_req", int'(imem_req), 0);
            chk("hold_acc_we", int'(acc_we), 0);
            chk("hold_flags_we", int'(flags_we), 0);
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("unhalt_pc", int'(pc), 0);
        chk("unhalt_halted", int'(halted), 0);

        // 6. Reset during WRITEBACK, then stray valid outside FETCH
        mem[0] = 8'h23;  // ADD 3
        do_reset();
        repeat (3) step();
        @(negedge clk);
        chk("wb_state", int'(state), 3);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wbrst_acc_we", int'(acc_we), 0);
        chk("wbrst_state", int'(state), 0);
        chk("wbrst_pc", int'(pc), 0);
        do_reset();
        step();
        ovr_data = 8'h7C;  // JMP 12 presented while in DECODE/EXECUTE
        ovr_en = 1'b1;
        step();
        step();
        ovr_en = 1'b0;
        @(negedge clk);
        chk("stray_state", int'(state), 3);
        chk("stray_alu_op", int'(alu_op), 1);
        chk("stray_alu_imm", int'(alu_imm), 3);
        chk("stray_pc", int'(pc), 1);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
